// File: rtl/psr_ctx_stack.sv
// Program status register with a LIFO context stack for nested interrupt/exception entry.
// Optional build macro PSR_CLEAR_ON_PUSH_EN: an effective push also clears the live flags.
module psr_ctx_stack #(
    parameter  int FLAG_W  = 5,
    parameter  int DEPTH   = 4,
    localparam int DEPTH_W = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [FLAG_W-1:0]  flags_i,
    input  logic [FLAG_W-1:0]  flag_we_i,
    input  logic               wr_en_i,
    input  logic [FLAG_W-1:0]  wr_data_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               err_clr_i,
    output logic [FLAG_W-1:0]  flags_o,
    output logic [DEPTH_W-1:0] depth_o,
    output logic               empty_o,
    output logic               full_o,
    output logic               ovf_o,
    output logic               unf_o
);

    localparam int                 IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);

`ifdef PSR_CLEAR_ON_PUSH_EN
    localparam bit CLEAR_ON_PUSH = 1'b1;
`else
    localparam bit CLEAR_ON_PUSH = 1'b0;
`endif

    logic [FLAG_W-1:0]  flags_q, flags_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic [FLAG_W-1:0]  stack_q [DEPTH];

    logic               is_empty, is_full;
    logic               push_only, pop_only, swap_req;
    logic               push_eff, pop_eff, swap_eff;
    logic               ovf_set, unf_set;
    logic [IDX_W-1:0]   push_idx, top_idx;
    logic [FLAG_W-1:0]  top_val;
    logic [FLAG_W-1:0]  alu_val, upd_val;
    logic               stack_we;
    logic [IDX_W-1:0]   stack_widx;

    assign is_empty  = (depth_q == '0);
    assign is_full   = (depth_q == DEPTH_MAX);

    assign push_only = push_i & ~pop_i;
    assign pop_only  = pop_i & ~push_i;
    assign swap_req  = push_i & pop_i;

    assign push_eff  = push_only & ~is_full;
    assign pop_eff   = pop_only & ~is_empty;
    assign swap_eff  = swap_req & ~is_empty;

    assign ovf_set   = push_only & is_full;
    assign unf_set   = (pop_only | swap_req) & is_empty;

    // Indices are only used when the matching operation is effective, so truncation is safe.
    assign push_idx  = IDX_W'(depth_q);
    assign top_idx   = IDX_W'(depth_q - 1'b1);
    assign top_val   = stack_q[top_idx];

    assign alu_val   = (flags_q & ~flag_we_i) | (flags_i & flag_we_i);
    assign upd_val   = wr_en_i ? wr_data_i : alu_val;

    always_comb begin
        flags_d    = upd_val;
        depth_d    = depth_q;
        stack_we   = 1'b0;
        stack_widx = push_idx;

        if (pop_eff || swap_eff) begin
            flags_d = top_val;
        end else if (push_eff && CLEAR_ON_PUSH) begin
            flags_d = '0;
        end

        if (push_eff) begin
            stack_we   = 1'b1;
            stack_widx = push_idx;
            depth_d    = depth_q + 1'b1;
        end else if (pop_eff) begin
            depth_d    = depth_q - 1'b1;
        end else if (swap_eff) begin
            stack_we   = 1'b1;
            stack_widx = top_idx;
        end

        // A new error in the same cycle as a clear request must survive.
        ovf_d = ovf_set | (ovf_q & ~err_clr_i);
        unf_d = unf_set | (unf_q & ~err_clr_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flags_q <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            flags_q <= flags_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            if (stack_we) begin
                stack_q[stack_widx] <= flags_q;
            end
        end
    end

    assign flags_o = flags_q;
    assign depth_o = depth_q;
    assign empty_o = is_empty;
    assign full_o  = is_full;
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;

endmodule

// File: tb/tb_psr_ctx_stack.sv
// Self-checking bench for psr_ctx_stack (FLAG_W=5, DEPTH=4); expected outputs queued per stimulus row.
module tb_psr_ctx_stack;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [4:0] flags_i = '0;
    logic [4:0] flag_we_i = '0;
    logic       wr_en_i = 1'b0;
    logic [4:0] wr_data_i = '0;
    logic       push_i = 1'b0;
    logic       pop_i = 1'b0;
    logic       err_clr_i = 1'b0;
    logic [4:0] flags_o;
    logic [2:0] depth_o;
    logic       empty_o, full_o, ovf_o, unf_o;

`ifdef PSR_CLEAR_ON_PUSH_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    typedef struct packed {
        logic [4:0] flags;
        logic [2:0] depth;
        logic       empty;
        logic       full;
        logic       ovf;
        logic       unf;
    } obs_t;

    typedef struct packed {
        logic       push;
        logic       pop;
        logic       wr;
        logic [4:0] wd;
        logic [4:0] we;
        logic [4:0] fi;
        logic       clr;
    } stim_t;

    obs_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    psr_ctx_stack #(.FLAG_W(5), .DEPTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flags_i(flags_i), .flag_we_i(flag_we_i),
        .wr_en_i(wr_en_i), .wr_data_i(wr_data_i), .push_i(push_i), .pop_i(pop_i),
        .err_clr_i(err_clr_i), .flags_o(flags_o), .depth_o(depth_o), .empty_o(empty_o),
        .full_o(full_o), .ovf_o(ovf_o), .unf_o(unf_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic obs_t mk(logic [4:0] f, logic [2:0] d, logic ov, logic un);
        obs_t o;
        o.flags = f;
        o.depth = d;
        o.empty = (d == 3'd0);
        o.full  = (d == 3'd4);
        o.ovf   = ov;
        o.unf   = un;
        return o;
    endfunction

    function automatic stim_t st(logic push, logic pop, logic wr, logic [4:0] wd,
                                 logic [4:0] we, logic [4:0] fi, logic clr);
        stim_t s;
        s.push = push; s.pop = pop; s.wr = wr; s.wd = wd;
        s.we = we; s.fi = fi; s.clr = clr;
        return s;
    endfunction

    // Live value expected after an effective push whose same-cycle update would give v.
    function automatic logic [4:0] pf(logic [4:0] v);
        return CLR ? 5'h00 : v;
    endfunction

    function automatic obs_t snap();
        obs_t o;
        o = {flags_o, depth_o, empty_o, full_o, ovf_o, unf_o};
        return o;
    endfunction

    task automatic apply(stim_t s);
        push_i = s.push; pop_i = s.pop; wr_en_i = s.wr; wr_data_i = s.wd;
        flag_we_i = s.we; flags_i = s.fi; err_clr_i = s.clr;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        obs_t exp, got;
        #2;
        sb.push_back(mk(5'h00, 3'd0, 1'b0, 1'b0));
        exp = sb.pop_front(); got = snap(); n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL reset_async: got %h need %h", got, exp);
        end
        tick();
        rst_i = 1'b0;
        apply(st(0,0,0,5'h00,5'h00,5'h00,0));
        sb.push_back(mk(5'h00, 3'd0, 1'b0, 1'b0));
        tick();
        exp = sb.pop_front(); got = snap(); n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL reset_idle: got %h need %h", got, exp);
        end
    endtask

    task automatic test_alu_update();
        stim_t s[$]; obs_t e[$]; obs_t exp, got;
        s.push_back(st(0,0,0,5'h00,5'h03,5'h1F,0)); e.push_back(mk(5'h03,3'd0,0,0));
        s.push_back(st(0,0,0,5'h00,5'h00,5'h1F,0)); e.push_back(mk(5'h03,3'd0,0,0));
        s.push_back(st(0,0,0,5'h00,5'h11,5'h10,0)); e.push_back(mk(5'h12,3'd0,0,0));
        s.push_back(st(0,0,1,5'h0A,5'h1F,5'h1F,0)); e.push_back(mk(5'h0A,3'd0,0,0));
        s.push_back(st(0,0,1,5'h00,5'h00,5'h00,0)); e.push_back(mk(5'h00,3'd0,0,0));
        foreach (s[i]) begin
            apply(s[i]); sb.push_back(e[i]); tick();
            exp = sb.pop_front(); got = snap(); n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL alu_update[%0d]: got flags=%h depth=%0d e/f/ovf/unf=%b%b%b%b need flags=%h depth=%0d e/f/ovf/unf=%b%b%b%b",
                         i, got.flags, got.depth, got.empty, got.full, got.ovf, got.unf,
                         exp.flags, exp.depth, exp.empty, exp.full, exp.ovf, exp.unf);
            end
        end
    endtask

    task automatic test_nesting();
        stim_t s[$]; obs_t e[$]; obs_t exp, got;
        s.push_back(st(0,0,1,5'h01,5'h00,5'h00,0)); e.push_back(mk(5'h01,3'd0,0,0));
        s.push_back(st(1,0,0,5'h00,5'h00,5'h00,0)); e.push_back(mk(pf(5'h01),3'd1,0,0));
        s.push_back(st(0,0,1,5'h02,5'h00,5'h00,0)); e.push_back(mk(5'h02,3'd1,0,0));
        s.push_back(st(1,0,0,5'h00,5'h00,5'h00,0)); e.push_back(mk(pf(5'h02),3'd2,0,0));
        s.push_back(st(0,0,1,5'h03,5'h00,5'h00,0)); e.push_back(mk(5'h03,3'd2,0,0));
        s.push_back(st(1,0,0,5'h00,5'h00,5'h00,0)); e.push_back(mk(pf(5'h03),3'd3,0,0));
        s.push_back(st(0,0,1,5'h04,5'h00,5'h00,0)); e.push_back(mk(5'h04,3'd3,0,0));
        s.push_back(st(1,0,0,5'h00,5'h00,5'h00,0)); e.push_back(mk(pf(5'h04),3'd4,0,0));
        // overflowing push with err_clr: set wins, live write still lands, no clear
        s.push_back(st(1,0,1,5'h07,5'h00,5'h00,1)); e.push_back(mk(5'h07,3'd4,1,0));
        s.push_back(st(0,1,0,5'h00,5'h00,5'h00,0)); e.push_back(mk(5'h04,3'd3,1,0));
        s.push_back(st(0,1,0,5'h00,5'h1F,5'h1F,0)); e.push_back(mk(5'h03,3'd2,1,0));
        s.push_back(st(0,1,0,5'h00,5'h00,5'h00,0)); e.push_back(mk(5'h02,3'd1,1,0));
        s.push_back(st(0,1,0,5'h00,5'h00,5'h00,0)); e.push_back(mk(5'h01,3'd0,1,0));
        s.push_back(st(0,0,0,5'h00,5'h00,5'h00,1)); e.push_back(mk(5'h01,3'd0,0,0));
        foreach (s[i]) begin
            apply(s[i]); sb.push_back(e[i]); tick();
            exp = sb.pop_front(); got = snap(); n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL nesting[%0d]: got flags=%h depth=%0d e/f/ovf/unf=%b%b%b%b need flags=%h depth=%0d e/f/ovf/unf=%b%b%b%b",
                         i, got.flags, got.depth, got.empty, got.full, got.ovf, got.unf,
                         exp.flags, exp.depth, exp.empty, exp.full, exp.ovf, exp.unf);
            end
        end
    endtask

    task automatic test_underflow();
        stim_t s[$]; obs_t e[$]; obs_t exp, got;
        s.push_back(st(0,1,0,5'h00,5'h1F,5'h1A,0)); e.push_back(mk(5'h1A,3'd0,0,1));
        s.push_back(st(0,0,0,5'h00,5'h00,5'h00,0)); e.push_back(mk(5'h1A,3'd0,0,1));
        s.push_back(st(0,0,0,5'h00,5'h00,5'h00,1)); e.push_back(mk(5'h1A,3'd0,0,0));
        s.push_back(st(1,1,1,5'h0C,5'h00,5'h00,0)); e.push_back(mk(5'h0C,3'd0,0,1));
        s.push_back(st(0,0,0,5'h00,5'h00,5'h00,1)); e.push_back(mk(5'h0C,3'd0,0,0));
        foreach (s[i]) begin
            apply(s[i]); sb.push_back(e[i]); tick();
            exp = sb.pop_front(); got = snap(); n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL underflow[%0d]: got flags=%h depth=%0d e/f/ovf/unf=%b%b%b%b need flags=%h depth=%0d e/f/ovf/unf=%b%b%b%b",
                         i, got.flags, got.depth, got.empty, got.full, got.ovf, got.unf,
                         exp.flags, exp.depth, exp.empty, exp.full, exp.ovf, exp.unf);
            end
        end
    endtask

    task automatic test_swap();
        stim_t s[$]; obs_t e[$]; obs_t exp, got;
        s.push_back(st(0,0,1,5'h10,5'h00,5'h00,0)); e.push_back(mk(5'h10,3'd0,0,0));
        s.push_back(st(1,0,0,5'h00,5'h00,5'h00,0)); e.push_back(mk(pf(5'h10),3'd1,0,0));
        s.push_back(st(0,0,1,5'h0F,5'h00,5'h00,0)); e.push_back(mk(5'h0F,3'd1,0,0));
        s.push_back(st(1,1,1,5'h1F,5'h00,5'h00,0)); e.push_back(mk(5'h10,3'd1,0,0));
        s.push_back(st(0,1,0,5'h00,5'h00,5'h00,0)); e.push_back(mk(5'h0F,3'd0,0,0));
        foreach (s[i]) begin
            apply(s[i]); sb.push_back(e[i]); tick();
            exp = sb.pop_front(); got = snap(); n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL swap[%0d]: got flags=%h depth=%0d e/f/ovf/unf=%b%b%b%b need flags=%h depth=%0d e/f/ovf/unf=%b%b%b%b",
                         i, got.flags, got.depth, got.empty, got.full, got.ovf, got.unf,
                         exp.flags, exp.depth, exp.empty, exp.full, exp.ovf, exp.unf);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[$]; obs_t e[$]; obs_t exp, got;
        s.push_back(st(0,0,1,5'h06,5'h00,5'h00,0)); e.push_back(mk(5'h06,3'd0,0,0));
        s.push_back(st(1,0,1,5'h09,5'h00,5'h00,0)); e.push_back(mk(pf(5'h09),3'd1,0,0));
        s.push_back(st(0,1,0,5'h00,5'h00,5'h00,0)); e.push_back(mk(5'h06,3'd0,0,0));
        s.push_back(st(1,0,1,5'h11,5'h00,5'h00,0)); e.push_back(mk(pf(5'h11),3'd1,0,0));
        s.push_back(st(1,0,1,5'h12,5'h00,5'h00,0)); e.push_back(mk(pf(5'h12),3'd2,0,0));
        s.push_back(st(0,1,0,5'h00,5'h00,5'h00,0)); e.push_back(mk(pf(5'h11),3'd1,0,0));
        s.push_back(st(0,1,0,5'h00,5'h00,5'h00,0)); e.push_back(mk(5'h06,3'd0,0,0));
        foreach (s[i]) begin
            apply(s[i]); sb.push_back(e[i]); tick();
            exp = sb.pop_front(); got = snap(); n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: got flags=%h depth=%0d e/f/ovf/unf=%b%b%b%b need flags=%h depth=%0d e/f/ovf/unf=%b%b%b%b",
                         i, got.flags, got.depth, got.empty, got.full, got.ovf, got.unf,
                         exp.flags, exp.depth, exp.empty, exp.full, exp.ovf, exp.unf);
            end
        end
    endtask

    task automatic test_clear_on_push();
        stim_t s[$]; obs_t e[$]; obs_t exp, got;
        s.push_back(st(0,0,1,5'h15,5'h00,5'h00,0)); e.push_back(mk(5'h15,3'd0,0,0));
        s.push_back(st(1,0,0,5'h00,5'h00,5'h00,0)); e.push_back(mk(CLR ? 5'h00 : 5'h15,3'd1,0,0));
        s.push_back(st(0,1,0,5'h00,5'h00,5'h00,0)); e.push_back(mk(5'h15,3'd0,0,0));
        foreach (s[i]) begin
            apply(s[i]); sb.push_back(e[i]); tick();
            exp = sb.pop_front(); got = snap(); n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL clear_on_push[%0d]: got flags=%h depth=%0d e/f/ovf/unf=%b%b%b%b need flags=%h depth=%0d e/f/ovf/unf=%b%b%b%b",
                         i, got.flags, got.depth, got.empty, got.full, got.ovf, got.unf,
                         exp.flags, exp.depth, exp.empty, exp.full, exp.ovf, exp.unf);
            end
        end
    endtask

    task automatic test_reset_mid();
        stim_t s[$]; obs_t e[$]; obs_t exp, got;
        s.push_back(st(0,1,0,5'h00,5'h00,5'h00,0)); e.push_back(mk(5'h15,3'd0,0,1));
        s.push_back(st(0,0,1,5'h1E,5'h00,5'h00,0)); e.push_back(mk(5'h1E,3'd0,0,1));
        s.push_back(st(1,0,0,5'h00,5'h00,5'h00,0)); e.push_back(mk(pf(5'h1E),3'd1,0,1));
        s.push_back(st(1,0,0,5'h00,5'h00,5'h00,0)); e.push_back(mk(pf(5'h1E),3'd2,0,1));
        s.push_back(st(1,0,0,5'h00,5'h00,5'h00,0)); e.push_back(mk(pf(5'h1E),3'd3,0,1));
        foreach (s[i]) begin
            apply(s[i]); sb.push_back(e[i]); tick();
            exp = sb.pop_front(); got = snap(); n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL reset_mid_pre[%0d]: got flags=%h depth=%0d e/f/ovf/unf=%b%b%b%b need flags=%h depth=%0d e/f/ovf/unf=%b%b%b%b",
                         i, got.flags, got.depth, got.empty, got.full, got.ovf, got.unf,
                         exp.flags, exp.depth, exp.empty, exp.full, exp.ovf, exp.unf);
            end
        end
        // push still requested while reset hits between edges
        #2;
        rst_i = 1'b1;
        sb.push_back(mk(5'h00, 3'd0, 1'b0, 1'b0));
        #1;
        exp = sb.pop_front(); got = snap(); n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL reset_mid_async: got %h need %h", got, exp);
        end
        tick();
        apply(st(0,0,0,5'h00,5'h00,5'h00,0));
        rst_i = 1'b0;
        sb.push_back(mk(5'h00, 3'd0, 1'b0, 1'b0));
        tick();
        exp = sb.pop_front(); got = snap(); n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL reset_mid_after: got %h need %h", got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout need completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_alu_update();
        test_nesting();
        test_underflow();
        test_swap();
        test_back_to_back();
        test_clear_on_push();
        test_reset_mid();
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left need 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/psr_ctx_stack.md
Name: psr_ctx_stack

Overview:
- Parametrised program status register with a hardware context stack for nested interrupt and exception entry.
- Holds the live flag word (default FLCNZ, 5 bits) and applies per-flag ALU updates under an externally decoded write mask.
- Saves and restores the flag word on push/pop, with sticky overflow/underflow error reporting.
- Sits between the ALU/decoder and the control unit's interrupt sequencer.

Parameters:
FLAG_W, 5, width of flag word (bit order FLCNZ at default, MSB..LSB)
DEPTH, 4, number of saved contexts (>=1)
DEPTH_W, $clog2(DEPTH+1), width of depth counter (derived, localparam)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
flags_i  in  FLAG_W  new flag values from ALU
flag_we_i  in  FLAG_W  per-bit update enable (decoded from ALU mode by decoder)
wr_en_i  in  1  explicit full write of live flags (move-to-PSR)
wr_data_i  in  FLAG_W  explicit write data
push_i  in  1  save live flags to stack (interrupt entry)
pop_i  in  1  restore live flags from stack (return from interrupt)
err_clr_i  in  1  clear sticky error bits
flags_o  out  FLAG_W  live flag register
depth_o  out  DEPTH_W  number of valid saved contexts
empty_o  out  1  depth_o == 0
full_o  out  1  depth_o == DEPTH
ovf_o  out  1  sticky: push attempted while full
unf_o  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (async, rst_i high): flags_o=0, depth_o=0, ovf_o=0, unf_o=0, stack storage=0. empty_o=1, full_o=0 (combinational from depth). Reset mid-push/pop discards the operation.
- All state updates on posedge clk_i; flags_o and depth_o reflect an operation one cycle after it is sampled. No combinational input-to-flags_o path.
- Live flag next-state priority, highest first:
  1. Effective pop or swap: flags_o <= stack top.
  2. wr_en_i: flags_o <= wr_data_i.
  3. ALU update: for each bit i, flags_o[i] <= flag_we_i[i] ? flags_i[i] : flags_o[i].
- Push only (push_i=1, pop_i=0):
  - Not full: stack[depth] <= current flags_o (pre-update value); depth+1.
  - Same-cycle wr/ALU update still applies to the live register.
  - Full: stack and depth unchanged; ovf_o set; live update still applies.
- Pop only:
  - Not empty: flags_o <= stack[depth-1]; depth-1. Same-cycle wr/ALU update is discarded.
  - Empty: unf_o set; pop ineffective, so wr/ALU update applies normally.
- push_i and pop_i together = swap:
  - Not empty: flags_o <= top and top <= current flags_o; depth unchanged; wr/ALU update discarded.
  - Empty: unf_o set; no stack change; wr/ALU update applies.
- Stack is LIFO indexed by depth; no wrap-around. Entries above depth are don't-care and are not cleared on pop.
- Sticky errors:
  - Set on the error cycle; held until err_clr_i or reset.
  - err_clr_i and a new error in the same cycle: the set wins.
- DEPTH=1 must be legal: full after one push.

Optional Feature:
- Macro PSR_CLEAR_ON_PUSH_EN.
- Defined: an effective push (not full, not swap) also loads flags_o <= 0, overriding same-cycle wr/ALU update, so each interrupt context starts with clean flags.
- Undefined: flags_o keeps its value, modified only by same-cycle wr/ALU update per the priority list.
- Overflowed push behaves identically in both builds (no clear).

Test Plan:
- Reset, then ALU update: flags_i=5'b11111, flag_we_i=5'b00011 -> flags_o=5'b00011 next cycle; then flag_we_i=0 -> value held.
- Nesting: wr 5'h01, push; wr 5'h02, push; wr 5'h03, push; wr 5'h04, push (DEPTH=4) -> full_o=1, depth_o=4; a fifth push sets ovf_o=1 and depth stays 4; four pops return flags_o 04, 03, 02, 01 in turn, then empty_o=1.
- Pop on empty with flag_we_i=5'b11111, flags_i=5'h1A -> unf_o=1, flags_o=5'h1A, depth_o=0; err_clr_i -> unf_o=0.
- Swap: live=5'h0F, top=5'h10 (depth 1), push_i=pop_i=1 with wr_en_i=1, wr_data_i=5'h1F -> flags_o=5'h10, top=5'h0F, depth_o=1.
- Pop with simultaneous ALU update (flag_we_i=all ones) -> flags_o = restored value, not flags_i; err_clr_i in same cycle as overflowing push -> ovf_o=1.
- Assert rst_i mid-sequence at depth 3, between clock edges -> all outputs reset immediately without a clock edge. With PSR_CLEAR_ON_PUSH_EN: push at live=5'h15 -> flags_o=0, top=5'h15.
